// File: rtl/alu_rs_pkg.sv
// Shared execution-unit defines: datapath width, reservation-station defaults,
// per-entry field layout and the issue payload carried to the arithmetic unit.
package alu_rs_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned RS_NUM_ENTRIES = 4;
    localparam int unsigned RS_TAG_W       = 4;

    // Per-entry field layout: valid, pc, inst, tag, then two sources of {ready, tag, value}
    localparam int unsigned RS_VALID_W = 1;
    localparam int unsigned RS_PC_W    = XLEN;
    localparam int unsigned RS_INST_W  = XLEN;
    localparam int unsigned RS_RDY_W   = 1;
    localparam int unsigned RS_VAL_W   = XLEN;

    // Total storage bits of one entry for a given tag width
    function automatic int unsigned rs_entry_bits(input int unsigned tag_w);
        return RS_VALID_W + RS_PC_W + RS_INST_W + tag_w
             + 2 * (RS_RDY_W + tag_w + RS_VAL_W);
    endfunction

    // Operand/instruction payload handed to the arithmetic unit on issue
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
    } alu_issue_t;

endpackage

// File: rtl/alu_rs_select.sv
// Oldest-eligible picker for the ALU reservation station.
// Ports:
//   eligible_i : per-entry eligible flags (valid and both sources ready)
//   older_i    : age matrix, bit [r*N+c] set when entry r is older than entry c
//   grant_c    : one-hot grant of the oldest eligible entry (combinational)
//   found_c    : at least one entry is eligible (combinational)
module alu_rs_select #(
    parameter int unsigned NUM_ENTRIES = 4
) (
    input  logic [NUM_ENTRIES-1:0]             eligible_i,
    input  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] older_i,
    output logic [NUM_ENTRIES-1:0]             grant_c,
    output logic                               found_c
);

    logic [NUM_ENTRIES-1:0] blocked;

    // An eligible entry wins unless some other eligible entry is older
    always_comb begin
        blocked = '0;
        grant_c = '0;
        for (int c = 0; c < int'(NUM_ENTRIES); c++) begin
            for (int r = 0; r < int'(NUM_ENTRIES); r++) begin
                if (r != c && eligible_i[r] && older_i[r*int'(NUM_ENTRIES) + c]) begin
                    blocked[c] = 1'b1;
                end
            end
            grant_c[c] = eligible_i[c] & ~blocked[c];
        end
        found_c = |eligible_i;
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched instructions until both source
// operands are available (captured at dispatch or from the CDB), then issues
// the oldest ready entry, one per cycle, to a single-cycle arithmetic unit.
// Ports:
//   clk_i, reset_i (sync, active-high), flush_i
//   dispatch_*      : dispatch handshake and instruction/operand info
//   cdb_*           : result broadcast used for operand wakeup
//   alu_request_o   : registered issue strobe
//   issue_*_o       : registered issue payload (held while strobe low)
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = RS_NUM_ENTRIES,
    parameter int unsigned TAG_W       = RS_TAG_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             dispatch_valid_i,
    output logic             dispatch_ready_o,
    input  logic [XLEN-1:0]  dispatch_pc_i,
    input  logic [XLEN-1:0]  dispatch_inst_i,
    input  logic [TAG_W-1:0] dispatch_tag_i,
    input  logic             rs1_ready_i,
    input  logic             rs2_ready_i,
    input  logic [XLEN-1:0]  rs1_value_i,
    input  logic [XLEN-1:0]  rs2_value_i,
    input  logic [TAG_W-1:0] rs1_tag_i,
    input  logic [TAG_W-1:0] rs2_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]  cdb_value_i,
    output logic             alu_request_o,
    output logic [XLEN-1:0]  issue_pc_o,
    output logic [XLEN-1:0]  issue_inst_o,
    output logic [XLEN-1:0]  issue_rs1_value_o,
    output logic [XLEN-1:0]  issue_rs2_value_o,
    output logic [TAG_W-1:0] issue_tag_o
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned AGE_W = NUM_ENTRIES * NUM_ENTRIES;

    // Entry storage
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [XLEN-1:0]        pc_q      [NUM_ENTRIES];
    logic [XLEN-1:0]        inst_q    [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_q     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] rs1_rdy_q;
    logic [NUM_ENTRIES-1:0] rs2_rdy_q;
    logic [TAG_W-1:0]       rs1_tag_q [NUM_ENTRIES];
    logic [TAG_W-1:0]       rs2_tag_q [NUM_ENTRIES];
    logic [XLEN-1:0]        rs1_val_q [NUM_ENTRIES];
    logic [XLEN-1:0]        rs2_val_q [NUM_ENTRIES];
    // Bit [r*N+c] set when entry r was dispatched before entry c
    logic [AGE_W-1:0]       older_q;

    alu_issue_t             issue_q;

    logic                   dispatch_fire;
    logic [IDX_W-1:0]       alloc_idx;
    logic [NUM_ENTRIES-1:0] alloc_oh;
    logic [NUM_ENTRIES-1:0] eligible;
    logic [NUM_ENTRIES-1:0] grant;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [NUM_ENTRIES-1:0] wake1;
    logic [NUM_ENTRIES-1:0] wake2;
    logic [NUM_ENTRIES-1:0] valid_d;
    logic [AGE_W-1:0]       older_d;
    logic                   disp_rs1_rdy;
    logic                   disp_rs2_rdy;
    logic [XLEN-1:0]        disp_rs1_val;
    logic [XLEN-1:0]        disp_rs2_val;

    // Ready reflects registered occupancy only; a slot freed by issue this cycle is not offered
    assign dispatch_ready_o = ~&valid_q;
    assign dispatch_fire    = dispatch_valid_i & dispatch_ready_o;
    assign eligible         = valid_q & rs1_rdy_q & rs2_rdy_q;

    alu_rs_select #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_select (
        .eligible_i (eligible),
        .older_i    (older_q),
        .grant_c    (grant),
        .found_c    (sel_found)
    );

    // Lowest free slot, one-hot allocation and grant index
    always_comb begin
        alloc_idx = '0;
        sel_idx   = '0;
        alloc_oh  = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            alloc_oh[i] = dispatch_fire && (alloc_idx == IDX_W'(i));
            if (grant[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // CDB wakeup of waiting sources in resident entries
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            wake1[i] = cdb_valid_i && valid_q[i] && !rs1_rdy_q[i] && (rs1_tag_q[i] == cdb_tag_i);
            wake2[i] = cdb_valid_i && valid_q[i] && !rs2_rdy_q[i] && (rs2_tag_q[i] == cdb_tag_i);
        end
    end

    // Same-cycle CDB bypass into the dispatched entry
    always_comb begin
        disp_rs1_rdy = rs1_ready_i | (cdb_valid_i && (rs1_tag_i == cdb_tag_i));
        disp_rs2_rdy = rs2_ready_i | (cdb_valid_i && (rs2_tag_i == cdb_tag_i));
        disp_rs1_val = rs1_ready_i ? rs1_value_i : cdb_value_i;
        disp_rs2_val = rs2_ready_i ? rs2_value_i : cdb_value_i;
    end

    // Next valid/age state: new entry is younger than every other entry
    always_comb begin
        valid_d = (valid_q & ~grant) | alloc_oh;
        older_d = older_q;
        for (int r = 0; r < int'(NUM_ENTRIES); r++) begin
            for (int c = 0; c < int'(NUM_ENTRIES); c++) begin
                if (alloc_oh[r]) begin
                    older_d[r*int'(NUM_ENTRIES) + c] = 1'b0;
                end else if (alloc_oh[c]) begin
                    older_d[r*int'(NUM_ENTRIES) + c] = 1'b1;
                end
            end
        end
    end

    // Entry, age and issue registers; reset beats flush beats normal operation
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q       <= '0;
            older_q       <= '0;
            alu_request_o <= 1'b0;
            issue_q       <= '0;
            issue_tag_o   <= '0;
        end else if (flush_i) begin
            valid_q       <= '0;
            alu_request_o <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            older_q       <= older_d;
            alu_request_o <= sel_found;
            if (sel_found) begin
                issue_q     <= '{pc:        pc_q[sel_idx],
                                 inst:      inst_q[sel_idx],
                                 rs1_value: rs1_val_q[sel_idx],
                                 rs2_value: rs2_val_q[sel_idx]};
                issue_tag_o <= tag_q[sel_idx];
            end
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                if (wake1[i]) begin
                    rs1_rdy_q[i] <= 1'b1;
                    rs1_val_q[i] <= cdb_value_i;
                end
                if (wake2[i]) begin
                    rs2_rdy_q[i] <= 1'b1;
                    rs2_val_q[i] <= cdb_value_i;
                end
            end
            if (dispatch_fire) begin
                pc_q[alloc_idx]      <= dispatch_pc_i;
                inst_q[alloc_idx]    <= dispatch_inst_i;
                tag_q[alloc_idx]     <= dispatch_tag_i;
                rs1_rdy_q[alloc_idx] <= disp_rs1_rdy;
                rs2_rdy_q[alloc_idx] <= disp_rs2_rdy;
                rs1_tag_q[alloc_idx] <= rs1_tag_i;
                rs2_tag_q[alloc_idx] <= rs2_tag_i;
                rs1_val_q[alloc_idx] <= disp_rs1_val;
                rs2_val_q[alloc_idx] <= disp_rs2_val;
            end
        end
    end

    assign issue_pc_o        = issue_q.pc;
    assign issue_inst_o      = issue_q.inst;
    assign issue_rs1_value_o = issue_q.rs1_value;
    assign issue_rs2_value_o = issue_q.rs2_value;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a queue-in-dispatch-order reference model
// predicts each cycle's outputs; a monitor compares after every rising edge.
module tb_alu_rs;

    localparam int NUM = 4;
    localparam int TW  = 4;

    logic          clk_i;
    logic          reset_i;
    logic          flush_i;
    logic          dispatch_valid_i;
    logic          dispatch_ready_o;
    logic [31:0]   dispatch_pc_i;
    logic [31:0]   dispatch_inst_i;
    logic [TW-1:0] dispatch_tag_i;
    logic          rs1_ready_i;
    logic          rs2_ready_i;
    logic [31:0]   rs1_value_i;
    logic [31:0]   rs2_value_i;
    logic [TW-1:0] rs1_tag_i;
    logic [TW-1:0] rs2_tag_i;
    logic          cdb_valid_i;
    logic [TW-1:0] cdb_tag_i;
    logic [31:0]   cdb_value_i;
    logic          alu_request_o;
    logic [31:0]   issue_pc_o;
    logic [31:0]   issue_inst_o;
    logic [31:0]   issue_rs1_value_o;
    logic [31:0]   issue_rs2_value_o;
    logic [TW-1:0] issue_tag_o;

    alu_rs #(.NUM_ENTRIES(NUM), .TAG_W(TW)) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .flush_i           (flush_i),
        .dispatch_valid_i  (dispatch_valid_i),
        .dispatch_ready_o  (dispatch_ready_o),
        .dispatch_pc_i     (dispatch_pc_i),
        .dispatch_inst_i   (dispatch_inst_i),
        .dispatch_tag_i    (dispatch_tag_i),
        .rs1_ready_i       (rs1_ready_i),
        .rs2_ready_i       (rs2_ready_i),
        .rs1_value_i       (rs1_value_i),
        .rs2_value_i       (rs2_value_i),
        .rs1_tag_i         (rs1_tag_i),
        .rs2_tag_i         (rs2_tag_i),
        .cdb_valid_i       (cdb_valid_i),
        .cdb_tag_i         (cdb_tag_i),
        .cdb_value_i       (cdb_value_i),
        .alu_request_o     (alu_request_o),
        .issue_pc_o        (issue_pc_o),
        .issue_inst_o      (issue_inst_o),
        .issue_rs1_value_o (issue_rs1_value_o),
        .issue_rs2_value_o (issue_rs2_value_o),
        .issue_tag_o       (issue_tag_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic [TW-1:0] tag;
        bit            r1;
        bit            r2;
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        logic [31:0]   v1;
        logic [31:0]   v2;
    } ent_t;

    typedef struct {
        bit            req;
        bit            rdy;
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic [TW-1:0] tag;
        logic [31:0]   v1;
        logic [31:0]   v2;
    } exp_t;

    ent_t mq[$];      // resident instructions, oldest first
    exp_t sbq[$];     // expected outputs, one per clock edge
    exp_t last_pl;
    int   n_vec  = 0;
    int   n_miss = 0;

    // Predict the effect of the coming edge from the current inputs
    task automatic step();
        exp_t e;
        ent_t n;
        bit   acc;
        int   sel;
        e.req = 1'b0;
        if (reset_i) begin
            mq.delete();
            last_pl = '{req: 1'b0, rdy: 1'b0, pc: 32'h0, inst: 32'h0, tag: '0, v1: 32'h0, v2: 32'h0};
        end else if (flush_i) begin
            mq.delete();
        end else begin
            acc = dispatch_valid_i && (mq.size() < NUM);
            sel = -1;
            foreach (mq[k]) if (sel < 0 && mq[k].r1 && mq[k].r2) sel = k;
            if (sel >= 0) begin
                e.req        = 1'b1;
                last_pl.pc   = mq[sel].pc;
                last_pl.inst = mq[sel].inst;
                last_pl.tag  = mq[sel].tag;
                last_pl.v1   = mq[sel].v1;
                last_pl.v2   = mq[sel].v2;
                mq.delete(sel);
            end
            if (cdb_valid_i) begin
                foreach (mq[k]) begin
                    if (!mq[k].r1 && mq[k].t1 == cdb_tag_i) begin mq[k].r1 = 1'b1; mq[k].v1 = cdb_value_i; end
                    if (!mq[k].r2 && mq[k].t2 == cdb_tag_i) begin mq[k].r2 = 1'b1; mq[k].v2 = cdb_value_i; end
                end
            end
            if (acc) begin
                n.pc   = dispatch_pc_i;
                n.inst = dispatch_inst_i;
                n.tag  = dispatch_tag_i;
                n.t1   = rs1_tag_i;
                n.t2   = rs2_tag_i;
                n.r1   = rs1_ready_i;
                n.v1   = rs1_value_i;
                n.r2   = rs2_ready_i;
                n.v2   = rs2_value_i;
                if (!n.r1 && cdb_valid_i && n.t1 == cdb_tag_i) begin n.r1 = 1'b1; n.v1 = cdb_value_i; end
                if (!n.r2 && cdb_valid_i && n.t2 == cdb_tag_i) begin n.r2 = 1'b1; n.v2 = cdb_value_i; end
                mq.push_back(n);
            end
        end
        e.rdy  = (mq.size() < NUM);
        e.pc   = last_pl.pc;
        e.inst = last_pl.inst;
        e.tag  = last_pl.tag;
        e.v1   = last_pl.v1;
        e.v2   = last_pl.v2;
        sbq.push_back(e);
    endtask

    task automatic tick();
        step();
        @(negedge clk_i);
    endtask

    task automatic clear_in();
        reset_i          = 1'b0;
        flush_i          = 1'b0;
        dispatch_valid_i = 1'b0;
        cdb_valid_i      = 1'b0;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] inst, input logic [TW-1:0] tag,
                        input bit r1, input logic [31:0] v1, input logic [TW-1:0] t1,
                        input bit r2, input logic [31:0] v2, input logic [TW-1:0] t2);
        dispatch_valid_i = 1'b1;
        dispatch_pc_i    = pc;
        dispatch_inst_i  = inst;
        dispatch_tag_i   = tag;
        rs1_ready_i      = r1;
        rs1_value_i      = v1;
        rs1_tag_i        = t1;
        rs2_ready_i      = r2;
        rs2_value_i      = v2;
        rs2_tag_i        = t2;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [31:0] v);
        cdb_valid_i = 1'b1;
        cdb_tag_i   = t;
        cdb_value_i = v;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs one step after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("alu_request", 32'(alu_request_o), 32'(e.req));
                chk("dispatch_ready", 32'(dispatch_ready_o), 32'(e.rdy));
                chk("issue_pc", issue_pc_o, e.pc);
                chk("issue_inst", issue_inst_o, e.inst);
                chk("issue_tag", 32'(issue_tag_o), 32'(e.tag));
                chk("issue_rs1", issue_rs1_value_o, e.v1);
                chk("issue_rs2", issue_rs2_value_o, e.v2);
            end
        end
    end

    initial begin
        dispatch_pc_i = '0; dispatch_inst_i = '0; dispatch_tag_i = '0;
        rs1_ready_i = 1'b0; rs2_ready_i = 1'b0; rs1_value_i = '0; rs2_value_i = '0;
        rs1_tag_i = '0; rs2_tag_i = '0; cdb_tag_i = '0; cdb_value_i = '0;
        last_pl = '{req: 1'b0, rdy: 1'b0, pc: 32'h0, inst: 32'h0, tag: '0, v1: 32'h0, v2: 32'h0};
        clear_in();
        reset_i = 1'b1;
        repeat (2) tick();
        clear_in();
        tick();

        // Ready ADD issues with its dispatch-time operands
        disp(32'h100, 32'h002081B3, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        tick(); clear_in();
        repeat (3) tick();

        // rs2 waits on tag 9, woken two cycles after dispatch
        disp(32'h104, 32'h00310233, 4'd4, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9);
        tick(); clear_in();
        tick();
        cdb(4'd9, 32'h10);
        tick(); clear_in();
        repeat (3) tick();

        // Dispatch-cycle bypass of rs1 from the CDB
        disp(32'h108, 32'h00418233, 4'd5, 1'b0, 32'd0, 4'd6, 1'b1, 32'd2, 4'd0);
        cdb(4'd6, 32'hAA);
        tick(); clear_in();
        repeat (3) tick();

        // Fill the station; wake youngest-but-one first, then two at once
        disp(32'h200, 32'h1, 4'd10, 1'b0, 32'd0, 4'd1, 1'b1, 32'd20, 4'd0); tick();
        disp(32'h204, 32'h2, 4'd11, 1'b0, 32'd0, 4'd2, 1'b1, 32'd21, 4'd0); tick();
        disp(32'h208, 32'h3, 4'd12, 1'b0, 32'd0, 4'd3, 1'b1, 32'd22, 4'd0); tick();
        disp(32'h20C, 32'h4, 4'd13, 1'b0, 32'd0, 4'd2, 1'b1, 32'd23, 4'd0); tick();
        disp(32'h210, 32'h5, 4'd14, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0); tick();
        clear_in();
        cdb(4'd3, 32'h33); tick(); clear_in();
        tick();
        cdb(4'd2, 32'h22); tick(); clear_in();
        repeat (2) tick();
        cdb(4'd1, 32'h11); tick(); clear_in();
        repeat (3) tick();

        // Full station flushed alongside a dispatch and a matching broadcast
        for (int i = 0; i < NUM; i++) begin
            disp(32'h300 + 32'(i), 32'h7, 4'(i), 1'b0, 32'd0, 4'd11, 1'b1, 32'd1, 4'd0);
            tick();
        end
        disp(32'h3F0, 32'h8, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        cdb(4'd11, 32'hBB);
        flush_i = 1'b1;
        tick(); clear_in();
        repeat (3) tick();

        // Reset while entries are pending and one is already selected
        disp(32'h400, 32'h9, 4'd1, 1'b0, 32'd0, 4'd14, 1'b1, 32'd3, 4'd0); tick();
        disp(32'h404, 32'hA, 4'd2, 1'b1, 32'd4, 4'd0, 1'b1, 32'd5, 4'd0); tick();
        disp(32'h408, 32'hB, 4'd3, 1'b1, 32'd6, 4'd0, 1'b1, 32'd7, 4'd0); tick();
        clear_in();
        reset_i = 1'b1;
        cdb(4'd14, 32'hCC);
        disp(32'h40C, 32'hC, 4'd4, 1'b1, 32'd8, 4'd0, 1'b1, 32'd9, 4'd0);
        flush_i = 1'b1;
        tick(); clear_in();
        cdb(4'd14, 32'hCC);
        tick(); clear_in();
        repeat (3) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            if ($urandom_range(1, 0) == 1)
                disp($urandom, $urandom, 4'($urandom_range(15, 0)),
                     1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 0)),
                     1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 0)));
            if ($urandom_range(1, 0) == 1)
                cdb(4'($urandom_range(15, 0)), $urandom);
            flush_i = ($urandom_range(63, 0) == 0);
            reset_i = ($urandom_range(255, 0) == 0);
            tick();
        end
        clear_in();
        repeat (4) tick();

        if (sbq.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter NUM_ENTRIES, 4, number of reservation-station entries (power of two, 2..8).
REQ-002 Parameter TAG_W, 4, width of ROB/result tag.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 flush_i  input  1  discard all entries (mispredict/exception).
REQ-006 dispatch_valid_i  input  1  dispatch offers an instruction.
REQ-007 dispatch_ready_o  output  1  a free entry exists; transfer when valid and ready both high.
REQ-008 dispatch_pc_i  input  32  instruction PC.
REQ-009 dispatch_inst_i  input  32  raw RV32I instruction word.
REQ-010 dispatch_tag_i  input  TAG_W  destination tag of the instruction.
REQ-011 rs1_ready_i, rs2_ready_i  input  1 each  source value present at dispatch.
REQ-012 rs1_value_i, rs2_value_i  input  32 each  source value, meaningful when ready.
REQ-013 rs1_tag_i, rs2_tag_i  input  TAG_W each  producer tag, meaningful when not ready.
REQ-014 cdb_valid_i  input  1  common-data-bus broadcast valid.
REQ-015 cdb_tag_i  input  TAG_W  broadcast producer tag.
REQ-016 cdb_value_i  input  32  broadcast result.
REQ-017 alu_request_o  output  1  issue strobe to the arithmetic unit.
REQ-018 issue_pc_o, issue_inst_o  output  32 each  issued PC and instruction word.
REQ-019 issue_rs1_value_o, issue_rs2_value_o  output  32 each  issued operands.
REQ-020 issue_tag_o  output  TAG_W  tag accompanying the writeback of the issued instruction.

Function
REQ-021 Each entry holds: valid, pc, inst, tag, and per source: ready, producer tag, 32-bit value.
REQ-022 dispatch_ready_o is combinational from registered valid bits: high iff at least one entry invalid; an entry freed by issue in cycle N is not reusable until N+1.
REQ-023 Accepted dispatch writes the lowest-index invalid entry; entry valid from the next cycle.
REQ-024 Wakeup: every cycle cdb_valid_i high, each valid entry source with ready=0 and tag equal to cdb_tag_i captures cdb_value_i and sets ready=1.
REQ-025 Dispatch bypass: if a dispatched source is not ready and cdb_valid_i with matching tag in the same cycle, the entry is written with that source ready and value cdb_value_i.
REQ-026 An entry is eligible when valid and both sources ready in registered state; an entry woken in cycle N is eligible in N+1.
REQ-027 Select: at most one issue per cycle; among eligible entries, the oldest by dispatch order is chosen.
REQ-028 Issue: selected entry invalidated at the edge; issue outputs registered, so alu_request_o and payload are valid exactly one cycle (N+1) per selection in N.
REQ-029 alu_request_o is low in every cycle without a selection in the prior cycle; payload outputs hold last value when alu_request_o low.
REQ-030 No backpressure from the arithmetic unit: it accepts every request (single-cycle unit).
REQ-031 flush_i at edge N: all entries invalid and alu_request_o low at N+1; flush overrides simultaneous dispatch, wakeup and issue.
REQ-032 Age order survives holes: entries freed out of order do not change relative age of remaining entries.

Reset
REQ-033 reset_i at an edge: all entries invalid, age state cleared, alu_request_o=0, all issue payload outputs=0; dispatch_ready_o=1 in the cycle after.
REQ-034 Reset mid-operation discards all entries and any pending issue with priority over flush_i and dispatch.

Structure
REQ-035 NUM_ENTRIES and TAG_W defaults, and the entry field layout constants, live in the shared defines package used by the execution units.
REQ-036 One sub-module alu_rs_select: combinational oldest-eligible picker returning one-hot grant and found flag.

Verification
REQ-037 Dispatch ADD (inst 0x002081B3, rs1=5, rs2=7 ready, tag 3) -> alu_request_o high 2 cycles after dispatch edge, operands 5/7, issue_tag_o=3.
REQ-038 Dispatch with rs2 waiting on tag 9; cdb tag 9 value 0x10 two cycles later -> issue next cycle after wakeup with rs2 value 0x10; no earlier issue.
REQ-039 Dispatch same cycle as cdb tag 6 value 0xAA while rs1 waits on tag 6 -> entry ready immediately, issue with rs1 0xAA.
REQ-040 Fill 4 entries, all waiting; dispatch_ready_o=0; wake entry 2 then entry 0 -> entry 0 not issued before entry 2 only if older; verify oldest-first among simultaneously eligible, and dispatch_ready_o=1 after first issue.
REQ-041 Full station, flush_i with concurrent dispatch and cdb -> next cycle all invalid, alu_request_o=0, dispatch_ready_o=1.
REQ-042 reset_i asserted while entries pending and an issue selected -> next cycle alu_request_o=0, payload outputs 0, no later issue of old entries.
